// File: rtl/r2r_dac_pkg.sv
// r2r_dac_pkg -- shared types and constants for the R2R ladder sample player.
//   dac_state_e       : playback controller states (IDLE, PRIME, RUN)
//   MID_CODE_DEFAULT  : ladder code that parks the output at mid-scale
//   SAMPLE_W          : width of one ladder sample
package r2r_dac_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2
   } dac_state_e;

   localparam logic [7:0] MID_CODE_DEFAULT = 8'h80;
   localparam int         SAMPLE_W         = 8;

endpackage

// File: rtl/r2r_dac_player_if.sv
// r2r_dac_player_if -- upstream sample stream into the player.
//   s_valid : sample on s_data is valid (source -> player)
//   s_data  : unsigned 8-bit sample     (source -> player)
//   s_ready : player can take a sample  (player -> source)
// Modports: master = sample source, slave = player.
interface r2r_dac_player_if;
   import r2r_dac_pkg::*;

   logic                s_valid;
   logic [SAMPLE_W-1:0] s_data;
   logic                s_ready;

   modport master (output s_valid, output s_data, input s_ready);
   modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/r2r_dac_player_sync_fifo.sv
// sync_fifo -- single-clock FIFO with show-ahead read data.
//   clk, reset        : clock, synchronous active-high reset (empties FIFO)
//   wr_en, wr_data    : push request (ignored while full)
//   rd_en, rd_data    : pop request (ignored while empty); rd_data is the head
//   full, empty       : status, from pointers carrying one extra wrap bit
//   count             : occupancy, 0..DEPTH
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic             push_s;
   logic             pop_s;

   // The extra MSB tells a full buffer (MSBs differ) from an empty one (equal).
   assign empty   = (wr_ptr_r == rd_ptr_r);
   assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign count   = wr_ptr_r - rd_ptr_r;
   assign rd_data = mem_r[rd_ptr_r[AW-1:0]];
   assign push_s  = wr_en && !full;
   assign pop_s   = rd_en && !empty;

   // Pointer update; both pointers wrap naturally modulo 2*DEPTH.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
         if (pop_s)  rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
   end

   // Storage write; contents need no reset because pointers define validity.
   always_ff @(posedge clk) begin
      if (push_s) mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/r2r_dac_player.sv
// r2r_dac_player -- buffers upstream samples and replays them onto an 8-bit
// R2R ladder at a programmable rate.
//   clk, reset     : clock, synchronous active-high reset
//   dac_en         : playback enable
//   rate_div       : sample period minus one, in clk cycles (latched on PRIME->RUN)
//   s_if (slave)   : s_valid / s_data / s_ready sample stream
//   R2R_outputs    : registered ladder code (MID_CODE when idle)
//   sample_strobe  : one-cycle pulse in the cycle R2R_outputs takes a new sample
//   underrun       : one-cycle pulse after a sample tick found the buffer empty
//   underrun_count : saturating underrun total, only when R2R_DAC_UNDERRUN_COUNT_EN
//                    is defined
module r2r_dac_player
   import r2r_dac_pkg::*;
#(
   parameter int         FIFO_DEPTH = 16,
   parameter logic [7:0] MID_CODE   = MID_CODE_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        dac_en,
   input  logic [15:0] rate_div,
   r2r_dac_player_if.slave s_if,
   output logic [7:0]  R2R_outputs,
   output logic        sample_strobe,
   output logic        underrun
`ifdef R2R_DAC_UNDERRUN_COUNT_EN
   ,
   output logic [15:0] underrun_count
`endif
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   dac_state_e          state_r;
   dac_state_e          state_next_s;
   logic [15:0]         divider_r;
   logic [15:0]         rate_lat_r;
   logic                tick_s;
   logic                wr_en_s;
   logic                rd_en_s;
   logic                fifo_full_s;
   logic                fifo_empty_s;
   logic [CNT_W-1:0]    fifo_count_s;
   logic [SAMPLE_W-1:0] fifo_head_s;

   assign s_if.s_ready = !fifo_full_s;
   assign wr_en_s      = s_if.s_valid && !fifo_full_s;
   // A write landing in the tick cycle is not visible yet, so an empty FIFO underruns.
   assign rd_en_s      = tick_s && !fifo_empty_s;

   sync_fifo #(
      .WIDTH (SAMPLE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en_s),
      .wr_data (s_if.s_data),
      .rd_en   (rd_en_s),
      .rd_data (fifo_head_s),
      .full    (fifo_full_s),
      .empty   (fifo_empty_s),
      .count   (fifo_count_s)
   );

   // Controller state register.
   always_ff @(posedge clk) begin
      if (reset) state_r <= ST_IDLE;
      else       state_r <= state_next_s;
   end

   // Next-state and sample tick; dropping dac_en wins over every other event.
   always_comb begin
      state_next_s = state_r;
      tick_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (dac_en) state_next_s = ST_PRIME;
            else        state_next_s = ST_IDLE;
         end
         ST_PRIME: begin
            if (!dac_en)                                        state_next_s = ST_IDLE;
            else if (fifo_count_s >= CNT_W'(FIFO_DEPTH / 2))    state_next_s = ST_RUN;
            else                                                state_next_s = ST_PRIME;
         end
         ST_RUN: begin
            if (!dac_en) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_RUN;
               tick_s       = (divider_r == rate_lat_r);
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Rate divider and playback outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         divider_r     <= 16'd0;
         rate_lat_r    <= 16'd0;
         R2R_outputs   <= MID_CODE;
         sample_strobe <= 1'b0;
         underrun      <= 1'b0;
      end else begin
         sample_strobe <= rd_en_s;
         underrun      <= tick_s && fifo_empty_s;
         // Divider only counts while staying in RUN, so RUN always starts from 0.
         if (state_r == ST_RUN && state_next_s == ST_RUN)
            divider_r <= tick_s ? 16'd0 : divider_r + 16'd1;
         else
            divider_r <= 16'd0;
         if (state_r == ST_PRIME && state_next_s == ST_RUN)
            rate_lat_r <= rate_div;
         if (state_next_s == ST_IDLE)
            R2R_outputs <= MID_CODE;
         else if (rd_en_s)
            R2R_outputs <= fifo_head_s;
      end
   end

`ifdef R2R_DAC_UNDERRUN_COUNT_EN
   // Saturating underrun counter, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset)
         underrun_count <= 16'd0;
      else if (tick_s && fifo_empty_s && underrun_count != 16'hFFFF)
         underrun_count <= underrun_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_r2r_dac_player.sv
// tb_r2r_dac_player -- scoreboard bench for r2r_dac_player. A behavioural
// model (sample queue plus tick timing from the cycle RUN began) predicts
// every strobe/underrun pulse; a monitor pops and compares them.
module tb_r2r_dac_player;

   localparam int         DEPTH = 16;
   localparam logic [7:0] MID   = 8'h80;

   logic        clk = 1'b0;
   logic        reset;
   logic        dac_en;
   logic [15:0] rate_div;
   logic [7:0]  R2R_outputs;
   logic        sample_strobe;
   logic        underrun;
`ifdef R2R_DAC_UNDERRUN_COUNT_EN
   logic [15:0] underrun_count;
`endif

   r2r_dac_player_if s_if();

   r2r_dac_player #(.FIFO_DEPTH(DEPTH), .MID_CODE(MID)) dut (
      .clk           (clk),
      .reset         (reset),
      .dac_en        (dac_en),
      .rate_div      (rate_div),
      .s_if          (s_if),
      .R2R_outputs   (R2R_outputs),
      .sample_strobe (sample_strobe),
      .underrun      (underrun)
`ifdef R2R_DAC_UNDERRUN_COUNT_EN
      ,
      .underrun_count(underrun_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int         due;
      bit         is_under;
      logic [7:0] code;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: 0 idle, 1 prime, 2 run
   int         m_state   = 0;
   logic [7:0] m_q[$];
   int         run_start = 0;
   int         m_rate    = 0;
   logic [7:0] exp_out   = MID;
   int         m_ucnt    = 0;
   bit         m_valid   = 1'b0;

   always @(negedge clk) begin
      int  cyc;
      bit  wr;
      cyc = int'($time / 10);
      if (reset === 1'b1) begin
         m_q.delete();
         m_state = 0;
         exp_out = MID;
         m_ucnt  = 0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         chk("r2r_level", {24'd0, R2R_outputs}, {24'd0, exp_out});
         chk("s_ready", {31'd0, s_if.s_ready}, (m_q.size() < DEPTH) ? 32'd1 : 32'd0);
`ifdef R2R_DAC_UNDERRUN_COUNT_EN
         chk("underrun_count", {16'd0, underrun_count}, m_ucnt);
`endif
         wr = (s_if.s_valid === 1'b1) && (m_q.size() < DEPTH);
         case (m_state)
            0: if (dac_en) m_state = 1;
            1: begin
               if (!dac_en) begin
                  m_state = 0; exp_out = MID;
               end else if (m_q.size() >= DEPTH / 2) begin
                  m_state = 2; m_rate = int'(rate_div); run_start = cyc + 1;
               end
            end
            default: begin
               if (!dac_en) begin
                  m_state = 0; exp_out = MID;
               end else if ((cyc - run_start) % (m_rate + 1) == m_rate) begin
                  if (m_q.size() > 0) begin
                     exp_out = m_q.pop_front();
                     sb.push_back('{cyc + 1, 1'b0, exp_out});
                  end else begin
                     sb.push_back('{cyc + 1, 1'b1, exp_out});
                     if (m_ucnt < 16'hFFFF) m_ucnt++;
                  end
               end
            end
         endcase
         if (wr) m_q.push_back(s_if.s_data);
      end
   end

   // Monitor: every pulse must match the oldest prediction due this cycle.
   always @(negedge clk) begin
      int   cyc;
      exp_t e;
      cyc = int'($time / 10);
      while (sb.size() > 0 && sb[0].due < cyc) begin
         e = sb.pop_front();
         n_checks++;
         n_errors++;
         $display("FAIL missed_pulse: got none expected %s code %0h due cycle %0d",
                  e.is_under ? "underrun" : "strobe", e.code, e.due);
      end
      if (sample_strobe === 1'b1 || underrun === 1'b1) begin
         if (sb.size() == 0 || sb[0].due != cyc) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_pulse: got strobe=%b underrun=%b expected none at cycle %0d",
                     sample_strobe, underrun, cyc);
         end else begin
            e = sb.pop_front();
            chk("pulse_strobe", {31'd0, sample_strobe}, e.is_under ? 32'd0 : 32'd1);
            chk("pulse_underrun", {31'd0, underrun}, e.is_under ? 32'd1 : 32'd0);
            chk("pulse_code", {24'd0, R2R_outputs}, {24'd0, e.code});
         end
      end
   end

   task automatic step(int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      reset = 1'b1; dac_en = 1'b0; rate_div = 16'd0;
      s_if.s_valid = 1'b0; s_if.s_data = 8'h00;
      step(2);
      reset = 1'b0;
      step(1);
      chk("reset_r2r", {24'd0, R2R_outputs}, {24'd0, MID});
      chk("reset_ready", {31'd0, s_if.s_ready}, 32'd1);
      chk("reset_strobe", {30'd0, sample_strobe, underrun}, 32'd0);

      // Enable with an empty buffer: stays primed, output parked
      dac_en = 1'b1;
      step(12);
      chk("prime_hold", {24'd0, R2R_outputs}, {24'd0, MID});

      // Eight samples at rate_div 3, then drain into underrun
      dac_en = 1'b0;
      step(1);
      for (int i = 0; i < 8; i++) begin
         s_if.s_valid = 1'b1; s_if.s_data = 8'h10 + 8'(i);
         step(1);
      end
      s_if.s_valid = 1'b0;
      rate_div = 16'd3; dac_en = 1'b1;
      step(45);
      chk("drained_hold", {24'd0, R2R_outputs}, 32'h17);

      // Fill to full while idle; the 17th offer is refused
      dac_en = 1'b0;
      step(1);
      for (int i = 0; i < 16; i++) begin
         s_if.s_valid = 1'b1; s_if.s_data = 8'h40 + 8'(i);
         step(1);
      end
      chk("full_ready", {31'd0, s_if.s_ready}, 32'd0);
      s_if.s_data = 8'hEE;
      step(1);

      // rate_div 0 with continuous supply
      rate_div = 16'd0; dac_en = 1'b1;
      for (int i = 0; i < 40; i++) begin
         s_if.s_data = 8'($urandom);
         step(1);
      end

      // Reset mid-run, then re-enable
      s_if.s_valid = 1'b0;
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      step(5);
      chk("rst_run_r2r", {24'd0, R2R_outputs}, {24'd0, MID});
      chk("rst_run_ready", {31'd0, s_if.s_ready}, 32'd1);
`ifdef R2R_DAC_UNDERRUN_COUNT_EN
      chk("rst_run_ucnt", {16'd0, underrun_count}, 32'd0);
`endif

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         if (i % 60 == 0) rate_div = 16'($urandom_range(0, 4));
         dac_en       = ($urandom_range(0, 24) != 0);
         s_if.s_valid = 1'($urandom_range(0, 1));
         s_if.s_data  = 8'($urandom);
         reset        = ($urandom_range(0, 249) == 0);
         step(1);
      end

      reset = 1'b0; dac_en = 1'b0; s_if.s_valid = 1'b0;
      step(4);
      chk("sb_drained", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/r2r_dac_player.md
R2R_DAC_PLAYER -- requirements
Module: r2r_dac_player

Interface
REQ-001 SHALL provide parameter FIFO_DEPTH, default 16, sample buffer depth (power of 2, >=4).
REQ-002 SHALL provide parameter MID_CODE, default 8'h80, ladder code driven when idle or after reset.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  input  1  system clock.
REQ-005 SHALL have port reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port dac_en  input  1  playback enable.
REQ-007 SHALL have port rate_div  input  16  sample period minus one, in clk cycles.
REQ-008 SHALL have port s_valid  input  1  upstream sample valid.
REQ-009 SHALL have port s_data  input  8  upstream unsigned sample.
REQ-010 SHALL have port s_ready  output  1  buffer can accept a sample.
REQ-011 SHALL have port R2R_outputs  output  8  registered code to the R2R ladder.
REQ-012 SHALL have port sample_strobe  output  1  one-cycle pulse when R2R_outputs takes a new sample.
REQ-013 SHALL have port underrun  output  1  one-cycle pulse when a sample tick finds the buffer empty.

Function
REQ-014 SHALL buffer samples in a FIFO of FIFO_DEPTH entries; s_ready = not full; a write occurs on s_valid && s_ready.
REQ-015 SHALL implement states IDLE, PRIME and RUN.
REQ-016 IDLE: divider held at 0; R2R_outputs = MID_CODE; FIFO keeps accepting writes; IDLE->PRIME when dac_en = 1.
REQ-017 PRIME: no reads; PRIME->RUN on the first cycle FIFO occupancy >= FIFO_DEPTH/2; rate_div latched on that transition.
REQ-018 RUN: divider increments each cycle; when divider == latched rate_div, divider <= 0 and a sample tick occurs; rate_div = 0 gives a tick every cycle.
REQ-019 On a tick with a non-empty FIFO, SHALL pop the head into R2R_outputs at that edge and assert sample_strobe in the same cycle R2R_outputs changes.
REQ-020 On a tick with an empty FIFO, SHALL hold R2R_outputs, not pop, and pulse underrun for one cycle; the state stays RUN.
REQ-021 First tick SHALL occur latched rate_div+1 cycles after entering RUN.
REQ-022 A write to an empty FIFO in the same cycle as a tick SHALL NOT bypass; that tick counts as underrun.
REQ-023 Simultaneous pop and write on a full FIFO: s_ready is low that cycle, so no write; occupancy is FIFO_DEPTH-1 next cycle.
REQ-024 dac_en = 0 in PRIME or RUN SHALL return to IDLE on the next edge; FIFO contents are retained; R2R_outputs = MID_CODE.
REQ-025 Occupancy and pointer arithmetic SHALL wrap modulo FIFO_DEPTH, with a separate full/empty distinction (extra pointer bit).

Reset
REQ-026 Reset SHALL give: state IDLE, FIFO empty, divider 0, R2R_outputs = MID_CODE, sample_strobe = 0, underrun = 0, and s_ready = 1 in the following cycle.
REQ-027 Reset asserted mid-RUN SHALL discard all buffered samples.

Configuration
REQ-028 Macro R2R_DAC_UNDERRUN_COUNT_EN defined: add output port underrun_count, 16 bits, saturating at 16'hFFFF, incremented per underrun pulse, cleared only by reset.
REQ-029 Macro undefined: port underrun_count and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Package r2r_dac_pkg SHALL hold the state enum type and the default MID_CODE constant.
REQ-031 FIFO SHALL be a sub-module named sync_fifo (parameters WIDTH and DEPTH; ports wr_en, rd_en, full, empty, count).

Verification
REQ-032 Reset, then dac_en = 1 with no writes -> state stays PRIME, R2R_outputs = 8'h80, no strobe or underrun.
REQ-033 Write 8 samples 0x10..0x17, dac_en = 1, rate_div = 3 -> strobes every 4 cycles; R2R_outputs steps 0x10..0x17 in order.
REQ-034 Continue REQ-033 with no further writes -> on the 9th tick, underrun pulses once and R2R_outputs holds 0x17.
REQ-035 dac_en = 0, write 16 samples -> s_ready = 0 after the 16th write; the 17th s_valid is not accepted.
REQ-036 rate_div = 0, FIFO full, s_valid held continuously -> one strobe per cycle; s_ready high from the cycle after the first pop; sequence gap-free.
REQ-037 Reset mid-RUN, then dac_en = 1 -> R2R_outputs = 8'h80, FIFO empty, PRIME re-entered; with the macro enabled, underrun_count = 0.
